// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared states and constants for the boot-fetch instruction memory
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam int          FAULT_MISALIGN = 0;
  localparam int          FAULT_RANGE    = 1;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - DEPTH x XLEN array, one write port, one registered read port
module imem_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rdata_q;

  // The array itself is never reset; the boot sequence zeroes it word by word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_boot_fetch.sv
// rtl/imem_boot_fetch.sv - instruction memory with clear/load boot sequence and registered fetch port
module imem_boot_fetch
  import imem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [XLEN-1:0]          ld_data,
  input  logic                     ld_last,
  output logic                     boot_done,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_instr,
  output logic [1:0]               rsp_fault
);

  localparam int AW = $clog2(DEPTH);

  state_e          state_q;
  logic [AW-1:0]   clr_idx_q;
  logic            ld_ready_q;
  logic            run_q;
  logic            rsp_valid_q;
  logic [1:0]      rsp_fault_q;
  logic [1:0]      fault_d;
  logic            accept;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] ram_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_idx_q  <= '0;
      ld_ready_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_idx_q <= clr_idx_q + AW'(1);
          if (clr_idx_q == AW'(DEPTH - 1)) begin
            state_q    <= LOAD;
            ld_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_valid && ld_last) begin
            state_q    <= RUN;
            ld_ready_q <= 1'b0;
            run_q      <= 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q    <= CLEAR;
          clr_idx_q  <= '0;
          ld_ready_q <= 1'b0;
          run_q      <= 1'b0;
        end
      endcase
    end
  end

  // Clear and load share the single write port; RUN never writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_idx_q;
      end
      LOAD: begin
        wr_en   = ld_valid;
        wr_addr = ld_addr;
        wr_data = ld_data;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  assign req_ready = run_q && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    fault_d                 = '0;
    fault_d[FAULT_MISALIGN] = |req_addr[1:0];
    fault_d[FAULT_RANGE]    = |req_addr[31:AW+2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_fault_q <= fault_d;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  imem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (accept),
    .raddr_i (req_addr[AW+1:2]),
    .rdata_o (ram_rdata)
  );

  assign ld_ready  = ld_ready_q;
  assign boot_done = run_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  // A faulted fetch still reads the RAM, but the word is masked by the registered fault.
  assign rsp_instr = (|rsp_fault_q) ? XLEN'(NOP_INSTR) : ram_rdata;

endmodule

// File: tb/tb_imem_boot_fetch.sv
// tb/tb_imem_boot_fetch.sv - self-checking bench for imem_boot_fetch at DEPTH 64 and DEPTH 16
module tb_imem_boot_fetch;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;

  logic        ld_ready_a, boot_done_a, req_ready_a, rsp_valid_a;
  logic [31:0] rsp_instr_a;
  logic [1:0]  rsp_fault_a;
  logic        ld_ready_b, boot_done_b, req_ready_b, rsp_valid_b;
  logic [31:0] rsp_instr_b;
  logic [1:0]  rsp_fault_b;

  int checks = 0;
  int failures = 0;

  // Reference state: memory images, and the response the consumer should see.
  logic [31:0] m64 [64];
  logic [31:0] m16 [16];
  bit          run;
  bit          ev;
  logic [31:0] ei64, ei16;
  logic [1:0]  ef64, ef16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  fault;
    logic [1:0]  fault16;
  } vec_t;
  vec_t vecs [9];

  imem_boot_fetch #(.XLEN(32), .DEPTH(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready_a),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .boot_done(boot_done_a),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_addr(req_addr),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr_a),
    .rsp_fault(rsp_fault_a)
  );

  imem_boot_fetch #(.XLEN(32), .DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready_b),
    .ld_addr(ld_addr[3:0]), .ld_data(ld_data), .ld_last(ld_last), .boot_done(boot_done_b),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_addr(req_addr),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr_b),
    .rsp_fault(rsp_fault_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] mfault(input logic [31:0] a, input int aw);
    logic [1:0] f;
    f[0] = (a % 4) != 0;
    f[1] = (a >> (aw + 2)) != 0;
    return f;
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a, input int depth);
    int idx;
    if (mfault(a, (depth == 64) ? 6 : 4) != 2'b00) return 32'h0000_0013;
    idx = int'((a / 4) % depth);
    return (depth == 64) ? m64[idx] : m16[idx];
  endfunction

  task automatic model_edge(input bit acc, input logic [31:0] a, input bit rr);
    if (acc) begin
      ev   = 1'b1;
      ei64 = mword(a, 64);
      ef64 = mfault(a, 6);
      ei16 = mword(a, 16);
      ef16 = mfault(a, 4);
    end else if (rr) begin
      ev = 1'b0;
    end
  endtask

  task automatic fetch_cycle(input logic [31:0] a, input bit rv, input bit rr);
    bit exp_rr;
    req_valid = rv;
    req_addr  = a;
    rsp_ready = rr;
    #1;
    exp_rr = run && (!ev || rr);
    chk("req_ready64", req_ready_a, exp_rr);
    chk("req_ready16", req_ready_b, exp_rr);
    step();
    model_edge(rv && exp_rr, a, rr);
    chk("rsp_valid64", rsp_valid_a, ev);
    chk("rsp_valid16", rsp_valid_b, ev);
    if (ev) begin
      chk("rsp_instr64", rsp_instr_a, ei64);
      chk("rsp_fault64", rsp_fault_a, ef64);
      chk("rsp_instr16", rsp_instr_b, ei16);
      chk("rsp_fault16", rsp_fault_b, ef16);
    end
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    chk("rst_ld_ready", ld_ready_a, 0);
    chk("rst_req_ready", req_ready_a, 0);
    chk("rst_boot_done", boot_done_a, 0);
    chk("rst_rsp_valid", rsp_valid_a, 0);
    chk("rst_rsp_instr", rsp_instr_a, 0);
    chk("rst_rsp_fault", rsp_fault_a, 0);
    chk("rst_ld_ready16", ld_ready_b, 0);
    chk("rst_rsp_valid16", rsp_valid_b, 0);
    step();
    foreach (m64[i]) m64[i] = '0;
    foreach (m16[i]) m16[i] = '0;
    run   = 1'b0;
    ev    = 1'b0;
    rst_n = 1'b1;
  endtask

  // Fetch requests are held asserted throughout CLEAR to show none is taken.
  task automatic clear_phase();
    req_valid = 1'b1;
    req_addr  = 32'h0;
    rsp_ready = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step();
      chk("clr_ld_ready64", ld_ready_a, k >= 64);
      chk("clr_ld_ready16", ld_ready_b, k >= 16);
      chk("clr_rsp_valid", rsp_valid_a | rsp_valid_b, 0);
      chk("clr_boot_done", boot_done_a, 0);
    end
    req_valid = 1'b0;
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d, input bit last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    #1;
    chk("load_ld_ready", ld_ready_a, 1);
    step();
    m64[a]      = d;
    m16[a[3:0]] = d;
    if (last) run = 1'b1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("load_boot_done64", boot_done_a, run);
    chk("load_boot_done16", boot_done_b, run);
  endtask

  initial begin
    rst_n     = 1'b0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    ld_last   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;

    vecs[0] = '{32'h0000_0000, 32'h00F0_0093, 2'b00, 2'b00};
    vecs[1] = '{32'h0000_0004, 32'h00A0_0093, 2'b00, 2'b00};
    vecs[2] = '{32'h0000_0008, 32'h0011_01B3, 2'b00, 2'b00};
    vecs[3] = '{32'h0000_000C, 32'h0000_0000, 2'b00, 2'b00};
    vecs[4] = '{32'h0000_0002, 32'h0000_0013, 2'b01, 2'b01};
    vecs[5] = '{32'h0000_0100, 32'h0000_0013, 2'b10, 2'b10};
    vecs[6] = '{32'h0000_0102, 32'h0000_0013, 2'b11, 2'b11};
    vecs[7] = '{32'h0000_0014, 32'h0000_0000, 2'b00, 2'b00};
    vecs[8] = '{32'h0000_0040, 32'h0000_0000, 2'b00, 2'b10};

    reset_dut();
    clear_phase();

    // Partial image, then reset: word 5 must come back cleared.
    load_word(6'd5, 32'hDEAD_BEEF, 1'b0);
    reset_dut();
    clear_phase();
    load_word(6'd0, 32'h00F0_0093, 1'b0);
    load_word(6'd1, 32'h00A0_0093, 1'b0);
    load_word(6'd2, 32'h0011_01B3, 1'b1);

    ld_valid = 1'b1;
    ld_addr  = 6'd0;
    ld_data  = 32'hFFFF_FFFF;
    step();
    ld_valid = 1'b0;
    chk("run_ld_ready", ld_ready_a, 0);

    for (int i = 0; i < 9; i++) begin
      fetch_cycle(vecs[i].addr, 1'b1, 1'b1);
      chk("vec_instr64", rsp_instr_a, vecs[i].instr);
      chk("vec_fault64", rsp_fault_a, vecs[i].fault);
      chk("vec_fault16", rsp_fault_b, vecs[i].fault16);
    end
    fetch_cycle(32'h0, 1'b0, 1'b1);

    fetch_cycle(32'h4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      fetch_cycle(32'h8, 1'b1, 1'b0);
      chk("hold_instr", rsp_instr_a, 32'h00A0_0093);
      chk("hold_valid", rsp_valid_a, 1);
    end
    fetch_cycle(32'h8, 1'b1, 1'b1);
    chk("release_instr", rsp_instr_a, 32'h0011_01B3);
    fetch_cycle(32'hC, 1'b1, 1'b0);

    // Reset in RUN with a response pending, then a random image and random fetches.
    reset_dut();
    clear_phase();
    for (int n = 0; n < 80; n++) begin
      for (int g = 0; g < int'($urandom % 3); g++) begin
        ld_valid = 1'b0;
        ld_addr  = 6'($urandom % 64);
        ld_data  = $urandom;
        step();
      end
      load_word(6'($urandom % 64), $urandom, n == 79);
    end

    for (int c = 0; c < 600; c++) begin
      logic [31:0] a;
      case ($urandom % 8)
        0, 1, 2, 3, 4: a = ($urandom % 64) * 4;
        5:             a = ($urandom % 64) * 4 + ($urandom % 4);
        6:             a = ($urandom % 16) * 4;
        default:       a = $urandom;
      endcase
      fetch_cycle(a, ($urandom % 4) != 0, ($urandom % 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
